// File: rtl/if_id_buffer.sv
// IF/ID skid buffer: 2-entry in-order FIFO of {pc, instr, misaligned}, one-cycle latency, no bypass.
// Backpressure: in_ready drops only when full and is built from registered state alone; flush empties it.
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misaligned,
    input  logic        out_ready,
    output logic [1:0]  occupancy
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } entry_t;

    entry_t     mem [2];
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ;
    logic       push;
    logic       pop;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign occupancy = occ;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage carries no reset; occ alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr, misaligned: (in_pc[1:0] != 2'b00)};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        out_pc         = 32'h0;
        out_instr      = NOP_INSTR;
        out_misaligned = 1'b0;
        if (out_valid) begin
            out_pc         = head.pc;
            out_instr      = head.instr;
            out_misaligned = head.misaligned;
        end
    end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), driven on out_instr whenever out_valid=0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  fetch stage presents pc/instr this cycle.
REQ-005 SHALL have port in_pc  input  32  fetched PC.
REQ-006 SHALL have port in_instr  input  32  fetched instruction word.
REQ-007 SHALL have port in_ready  output  1  buffer accepts an entry this cycle.
REQ-008 SHALL have port flush  input  1  redirect (same cycle as fetch take_force_pc); discards all held and incoming entries.
REQ-009 SHALL have port out_valid  output  1  head entry valid for decode.
REQ-010 SHALL have port out_pc  output  32  head entry PC.
REQ-011 SHALL have port out_instr  output  32  head entry instruction.
REQ-012 SHALL have port out_misaligned  output  1  head entry PC has in_pc[1:0]!=0.
REQ-013 SHALL have port out_ready  input  1  decode consumes head this cycle.
REQ-014 SHALL have port occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 SHALL be a 2-entry in-order FIFO (skid buffer) of {pc, instr, misaligned}, with 1-bit read/write pointers wrapping 1->0.
REQ-016 in_ready SHALL equal (occupancy!=2), derived from registered state only; no combinational path from out_ready or flush.
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; entry written at write pointer, pointer increments.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; read pointer increments.
REQ-019 out_valid SHALL equal (occupancy!=0); out_pc/out_instr/out_misaligned SHALL come from the entry at the read pointer.
REQ-020 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on outputs after edge N; no same-cycle in->out bypass.
REQ-021 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-022 occupancy=2 SHALL block push (in_ready=0) regardless of out_ready in that cycle; pop still allowed.
REQ-023 out_ready with occupancy=0 SHALL have no effect (no underflow).
REQ-024 flush=1 SHALL, at the next edge, set occupancy=0 and both pointers=0, and SHALL suppress push and pop in that cycle.
REQ-025 When out_valid=0, out_instr SHALL be NOP_INSTR, out_pc SHALL be 32'h0, out_misaligned SHALL be 0.
REQ-026 Storage registers need not be reset; only pointers and occupancy are state-critical.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force occupancy=0, pointers=0, out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_pc=0.
REQ-028 Reset asserted mid-operation SHALL discard all held entries; no entry SHALL be output after reset deassertion until a new push.
REQ-029 First push SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-030 Single pass: push {pc=0x100, instr=0x00500093}, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x00500093; following cycle out_valid=0, out_instr=0x00000013.
REQ-031 Fill/backpressure: out_ready=0, push 0x100, 0x104, 0x108 on consecutive cycles -> first two accepted, occupancy=2, in_ready=0 on third; then out_ready=1 -> outputs 0x100, 0x104 in order, 0x108 accepted only once in_ready=1.
REQ-032 Streaming: in_valid=1 and out_ready=1 every cycle for pcs 0x0..0x3C -> occupancy stays 1 after first cycle, outputs 0x0..0x3C with no gaps, pointers wrap correctly.
REQ-033 Flush: occupancy=2 (0x200, 0x204), flush=1 with in_valid=1 pc=0x208 -> next cycle occupancy=0, out_valid=0; 0x208 never appears.
REQ-034 Async reset: occupancy=1, assert reset mid-cycle -> out_valid=0 and in_ready=1 before next edge; after deassert, outputs stay NOP until new push.
REQ-035 Misaligned: push pc=0x102 -> out_misaligned=1 with out_pc=0x102; next pc=0x104 -> out_misaligned=0.
